// File: rtl/instruction_fetch.sv
// Fetch front end: owns the PC, issues in-order word reads to instruction memory,
// buffers responses for decode and drops stale responses after a redirect.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {S_FETCH = 1'b0, S_DRAIN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] fq_rd_q, fq_rd_d, fq_wr_q, fq_wr_d;
  logic [31:0]   buf_data_q [DEPTH];
  logic [31:0]   buf_data_d [DEPTH];
  logic [31:0]   buf_pc_q   [DEPTH];
  logic [31:0]   buf_pc_d   [DEPTH];
  logic [31:0]   fq_pc_q    [DEPTH];
  logic [31:0]   fq_pc_d    [DEPTH];
  logic          boot_q, boot_d;
  logic [CW:0]   credit_used;
  logic [CW-1:0] new_discard;
  logic          req_fire, pop, rsp_take;
  logic          unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc[1:0];

  // Credit counts registered occupancy only, so a same-cycle pop does not free a slot.
  assign credit_used    = {1'b0, outst_q} + {1'b0, count_q};
  assign imem_req_valid = !rst && !boot_q && (state_q == S_FETCH) && !redirect_valid
                          && (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign instr_valid = !rst && (count_q != '0);
  assign instr_out   = instr_valid ? buf_data_q[rd_ptr_q] : '0;
  assign instr_pc    = instr_valid ? buf_pc_q[rd_ptr_q]   : '0;
  assign pop         = instr_valid && instr_ready;

  assign new_discard = outst_q - CW'(imem_rsp_valid);
  assign rsp_take    = imem_rsp_valid && (discard_q == '0);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    outst_d    = outst_q;
    discard_d  = discard_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fq_rd_d    = fq_rd_q;
    fq_wr_d    = fq_wr_q;
    buf_data_d = buf_data_q;
    buf_pc_d   = buf_pc_q;
    fq_pc_d    = fq_pc_q;
    boot_d     = 1'b0;

    if (redirect_valid) begin
      pc_d     = {redirect_pc[31:2], 2'b00};
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      if (state_q == S_FETCH) begin
        fq_rd_d   = '0;
        fq_wr_d   = '0;
        discard_d = new_discard;
        outst_d   = new_discard;
        state_d   = (new_discard != '0) ? S_DRAIN : S_FETCH;
      end else if (imem_rsp_valid) begin
        discard_d = discard_q - CW'(1);
        outst_d   = outst_q - CW'(1);
        if (discard_q == CW'(1)) state_d = S_FETCH;
      end
    end else if (state_q == S_DRAIN) begin
      if (imem_rsp_valid) begin
        discard_d = discard_q - CW'(1);
        outst_d   = outst_q - CW'(1);
        if (discard_q == CW'(1)) state_d = S_FETCH;
      end
    end else begin
      if (req_fire) begin
        pc_d             = pc_q + 32'd4;
        fq_pc_d[fq_wr_q] = pc_q;
        fq_wr_d          = fq_wr_q + PW'(1);
      end
      if (rsp_take) begin
        buf_data_d[wr_ptr_q] = imem_rsp_data;
        buf_pc_d[wr_ptr_q]   = fq_pc_q[fq_rd_q];
        wr_ptr_d             = wr_ptr_q + PW'(1);
        fq_rd_d              = fq_rd_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      outst_d = outst_q + CW'(req_fire) - CW'(rsp_take);
      count_d = count_q + CW'(rsp_take) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      outst_q   <= '0;
      discard_q <= '0;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      fq_rd_q   <= '0;
      fq_wr_q   <= '0;
      boot_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      fq_rd_q   <= fq_rd_d;
      fq_wr_q   <= fq_wr_d;
      boot_q    <= boot_d;
    end
    buf_data_q <= buf_data_d;
    buf_pc_q   <= buf_pc_d;
    fq_pc_q    <= fq_pc_d;
  end

  a_no_spurious_rsp: assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && (outst_q == '0)));

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: in-order memory model with variable latency,
// queue-based reference model, reset table, directed corner sequences and random traffic.
module tb_instruction_fetch;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam logic [31:0] XORK  = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr_out, instr_pc;

  instruction_fetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct { logic [31:0] addr; int due; } mem_t;
  typedef struct { logic [31:0] data; logic [31:0] pc; } ent_t;
  typedef struct {
    logic rst; logic ir;
    logic rv; logic [31:0] addr; logic iv; logic [31:0] pc;
  } vec_t;

  mem_t        memq[$];
  int          lat      = 1;
  bit          lat_rand = 1'b0;

  ent_t        m_buf[$];
  logic [31:0] m_infl[$];
  int          m_stale = 0;
  logic [31:0] m_pc    = '0;
  bit          m_boot  = 1'b0;

  logic        s_rv, s_iv, s_fire;
  logic [31:0] s_addr, s_pc, s_out;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: check outputs against the model mid-cycle, advance model and memory,
  // then drive the memory response for the next cycle.
  task automatic cycle();
    logic m_rv, fire_m, pop_m;
    ent_t e;
    @(negedge clk);
    s_rv = imem_req_valid; s_addr = imem_req_addr;
    s_iv = instr_valid;    s_pc   = instr_pc; s_out = instr_out;
    m_rv = !rst && !m_boot && !redirect_valid && (m_stale == 0)
           && (m_infl.size() + m_buf.size() < DEPTH);
    chk("req_valid", 32'(s_rv), 32'(m_rv));
    if (m_rv) chk("req_addr", s_addr, m_pc);
    chk("instr_valid", 32'(s_iv), 32'(!rst && m_buf.size() > 0));
    if (!rst && m_buf.size() > 0) begin
      chk("instr_pc", s_pc, m_buf[0].pc);
      chk("instr_out", s_out, m_buf[0].data);
    end else if (rst || m_boot) begin
      chk("instr_pc_zero", s_pc, 32'h0);
      chk("instr_out_zero", s_out, 32'h0);
    end

    s_fire = s_rv && imem_req_ready;
    if (rst) memq.delete();
    else if (s_fire) memq.push_back('{addr: s_addr, due: cyc + (lat_rand ? int'($urandom_range(4, 1)) : lat)});

    fire_m = m_rv && imem_req_ready;
    pop_m  = !rst && (m_buf.size() > 0) && instr_ready;
    if (rst) begin
      m_pc = RPC; m_buf.delete(); m_infl.delete(); m_stale = 0; m_boot = 1'b1;
    end else begin
      m_boot = 1'b0;
      if (redirect_valid) begin
        m_buf.delete();
        m_pc = {redirect_pc[31:2], 2'b00};
        if (m_stale == 0) begin
          m_stale = m_infl.size() - (imem_rsp_valid ? 1 : 0);
          m_infl.delete();
        end else if (imem_rsp_valid) m_stale--;
      end else if (m_stale > 0) begin
        if (imem_rsp_valid) m_stale--;
      end else begin
        if (pop_m) void'(m_buf.pop_front());
        if (imem_rsp_valid) begin
          if (m_infl.size() == 0) begin
            errors++;
            $display("FAIL rsp_order: response with no modelled request (cycle %0d)", cyc);
          end else begin
            e.pc = m_infl.pop_front(); e.data = imem_rsp_data;
            m_buf.push_back(e);
          end
        end
        if (fire_m) begin m_infl.push_back(m_pc); m_pc = m_pc + 32'd4; end
      end
    end

    @(posedge clk);
    cyc++;
    #1;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memq[0].addr ^ XORK;
      void'(memq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic first_req(input string name, input logic [31:0] exp);
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      cycle();
      if (s_rv) begin chk(name, s_addr, exp); seen = 1'b1; end
    end
    if (!seen) chk({name, "_timeout"}, 32'h0, 32'h1);
  endtask

  task automatic first_instr(input string name, input logic [31:0] exp);
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      cycle();
      if (s_iv) begin chk(name, s_pc, exp); seen = 1'b1; end
    end
    if (!seen) chk({name, "_timeout"}, 32'h0, 32'h1);
  endtask

  initial begin
    int nf;
    rst = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
    cycle();

    // reset sequence with a 1-cycle memory and decode always ready
    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 32'h104, 1'b0, 32'h0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 32'h108, 1'b1, 32'h100};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 32'h10C, 1'b1, 32'h104};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 32'h110, 1'b1, 32'h108};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 32'h114, 1'b1, 32'h10C};
    lat = 1; lat_rand = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rst = tbl[i].rst; instr_ready = tbl[i].ir;
      cycle();
      chk($sformatf("tbl%0d_req_valid", i), 32'(s_rv), 32'(tbl[i].rv));
      if (tbl[i].rv) chk($sformatf("tbl%0d_req_addr", i), s_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_instr_valid", i), 32'(s_iv), 32'(tbl[i].iv));
      if (tbl[i].iv) begin
        chk($sformatf("tbl%0d_instr_pc", i), s_pc, tbl[i].pc);
        chk($sformatf("tbl%0d_instr_out", i), s_out, tbl[i].pc ^ XORK);
      end
    end
    rst = 1'b0;
    repeat (6) cycle();

    // decode stalled: buffer fills, requests stop, then drains with nothing lost
    instr_ready = 1'b0;
    repeat (10) cycle();
    chk("bp_req_stopped", 32'(s_rv), 32'h0);
    chk("bp_head_valid", 32'(s_iv), 32'h1);
    instr_ready = 1'b1;
    repeat (20) cycle();

    // memory stalls with 0x108 pending
    do_reset();
    nf = 0;
    for (int k = 0; k < 20 && nf < 2; k++) begin cycle(); if (s_fire) nf++; end
    chk("stall_setup", 32'(nf), 32'd2);
    imem_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("stall_valid", 32'(s_rv), 32'h1);
      chk("stall_addr", s_addr, 32'h108);
    end
    imem_req_ready = 1'b1;
    repeat (10) cycle();

    // redirect with two requests outstanding on a 3-cycle memory
    do_reset();
    lat = 3;
    for (int k = 0; k < 20; k++) begin
      if (m_infl.size() == 2 && !imem_rsp_valid && m_buf.size() == 0) break;
      cycle();
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2000;
    cycle();
    redirect_valid = 1'b0;
    first_req("drain_first_req", 32'h2000);
    first_instr("drain_first_pc", 32'h2000);
    repeat (8) cycle();

    // redirect coinciding with a response and a pop, unaligned target
    do_reset();
    for (int k = 0; k < 20; k++) begin
      if (m_infl.size() == 2 && m_buf.size() >= 1 && imem_rsp_valid) break;
      cycle();
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2003;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    chk("rr_buffer_empty", 32'(s_iv), 32'h0);
    first_req("rr_first_req", 32'h2000);
    first_instr("rr_first_pc", 32'h2000);
    repeat (8) cycle();

    // reset with a full buffer
    lat = 1; instr_ready = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (m_buf.size() == DEPTH) break;
      cycle();
    end
    chk("full_before_rst", 32'(instr_valid), 32'h1);
    do_reset();
    instr_ready = 1'b1;
    cycle();
    chk("post_rst_instr_valid", 32'(s_iv), 32'h0);
    chk("post_rst_req_valid", 32'(s_rv), 32'h0);
    first_req("post_rst_first_req", RPC);
    first_instr("post_rst_first_pc", RPC);

    // random traffic against the reference model
    lat_rand = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      imem_req_ready = ($urandom_range(3, 0) != 0);
      instr_ready    = ($urandom_range(3, 0) != 0);
      redirect_valid = ($urandom_range(39, 0) == 0);
      redirect_pc    = $urandom;
      rst            = ($urandom_range(299, 0) == 0);
      cycle();
    end
    rst = 1'b0; redirect_valid = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b1;
    repeat (20) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
